// File: rtl/rr_mux_arb.sv
// N-channel round-robin arbitrated word mux with a registered valid/ready output stage.
// Optional packet lock (in_last/out_last ports) is enabled by defining MUX_ARB_LOCK_EN.
module rr_mux_arb #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NCH*WIDTH-1:0]                 in_data,
  input  logic [NCH-1:0]                       in_valid,
  output logic [NCH-1:0]                       in_ready,
  output logic [WIDTH-1:0]                     out_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_sel,
  output logic                                 out_valid,
  input  logic                                 out_ready
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic [NCH-1:0]                       in_last,
  output logic                                 out_last
`endif
);

  localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gnt;
  logic [SELW-1:0]  ptr_nxt;
  logic [WIDTH-1:0] gnt_data;
  logic             found;
  logic             load;
  logic             accept;
  int unsigned      scan_idx;
`ifdef MUX_ARB_LOCK_EN
  logic             lock;
`endif

  // Output register is free or being drained this cycle.
  assign load   = !out_valid || out_ready;
  assign accept = rst_n && load && found;

  // Round-robin search starting at ptr; a held packet lock bypasses the search.
  always_comb begin
    found    = 1'b0;
    gnt      = '0;
    scan_idx = 0;
`ifdef MUX_ARB_LOCK_EN
    if (lock) begin
      found = in_valid[ptr];
      gnt   = ptr;
    end else
`endif
    begin
      for (int unsigned k = 0; k < NCH; k++) begin
        scan_idx = 32'(ptr) + k;
        if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
        if (!found && in_valid[SELW'(scan_idx)]) begin
          found = 1'b1;
          gnt   = SELW'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt == SELW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Explicit wrap so non-power-of-2 channel counts return to 0.
  assign ptr_nxt = (32'(gnt) == NCH - 1) ? '0 : gnt + SELW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
`ifdef MUX_ARB_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
`endif
    end else if (accept) begin
      out_data  <= gnt_data;
      out_sel   <= gnt;
      out_valid <= 1'b1;
`ifdef MUX_ARB_LOCK_EN
      out_last  <= in_last[gnt];
      lock      <= !in_last[gnt];
      ptr       <= in_last[gnt] ? ptr_nxt : gnt;
`else
      ptr       <= ptr_nxt;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
